// File: rtl/period_gen_if.sv
// Request/response bundle for period_gen: burst request in, status and square wave out.
interface period_gen_if;
  logic        start;
  logic [19:0] prd;
  logic [7:0]  n_cyc;
  logic        ready;
  logic        done_tick;
  logic        err;
  logic        so;

  modport master (output start, prd, n_cyc, input ready, done_tick, err, so);
  modport slave  (input start, prd, n_cyc, output ready, done_tick, err, so);
endinterface

// File: rtl/period_gen.sv
// Burst square-wave generator: n_cyc periods of prd microseconds, high phase gets the odd microsecond.
module period_gen #(
  parameter int MAX_COUNTER_NUMBER = 50
) (
  input logic         clk,
  input logic         reset,
  period_gen_if.slave bus
);
  typedef enum logic [1:0] {IDLE, HIGH, LOW, DONE} state_t;

  localparam logic [6:0] T_LAST = 7'(MAX_COUNTER_NUMBER - 1);

  state_t      state, state_nx;
  logic [19:0] prd_reg, prd_nx;
  logic [19:0] hi_us, hi_nx;
  logic [19:0] u_reg, u_nx;
  logic [6:0]  t_reg, t_nx;
  logic [7:0]  cnt_reg, cnt_nx;
  logic        so_reg, so_nx;
  logic        err_reg, err_nx;
  logic [19:0] lo_us;
  logic        t_wrap;

  // Low phase length follows from the latched period, so it never drifts from hi_us.
  assign lo_us  = prd_reg - hi_us;
  assign t_wrap = (t_reg == T_LAST);

  always_comb begin
    state_nx = state;
    prd_nx   = prd_reg;
    hi_nx    = hi_us;
    u_nx     = u_reg;
    t_nx     = t_reg;
    cnt_nx   = cnt_reg;
    so_nx    = so_reg;
    err_nx   = err_reg;
    case (state)
      IDLE: begin
        if (bus.start) begin
          prd_nx = bus.prd;
          cnt_nx = bus.n_cyc;
          hi_nx  = bus.prd - (bus.prd >> 1);
          if (bus.prd < 20'd2 || bus.n_cyc == 8'd0) begin
            state_nx = DONE;
            err_nx   = 1'b1;
            so_nx    = 1'b0;
          end else begin
            state_nx = HIGH;
            so_nx    = 1'b1;
            t_nx     = '0;
            u_nx     = '0;
            err_nx   = 1'b0;
          end
        end
      end
      HIGH: begin
        t_nx = t_wrap ? 7'd0 : t_reg + 7'd1;
        u_nx = t_wrap ? u_reg + 20'd1 : u_reg;
        if (t_wrap && u_reg == hi_us - 20'd1) begin
          state_nx = LOW;
          so_nx    = 1'b0;
          t_nx     = '0;
          u_nx     = '0;
        end
      end
      LOW: begin
        t_nx = t_wrap ? 7'd0 : t_reg + 7'd1;
        u_nx = t_wrap ? u_reg + 20'd1 : u_reg;
        if (t_wrap && u_reg == lo_us - 20'd1) begin
          cnt_nx = cnt_reg - 8'd1;
          t_nx   = '0;
          u_nx   = '0;
          if (cnt_reg == 8'd1) begin
            state_nx = DONE;
            so_nx    = 1'b0;
          end else begin
            state_nx = HIGH;
            so_nx    = 1'b1;
          end
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      prd_reg <= '0;
      hi_us   <= '0;
      u_reg   <= '0;
      t_reg   <= '0;
      cnt_reg <= '0;
      so_reg  <= 1'b0;
      err_reg <= 1'b0;
    end else begin
      state   <= state_nx;
      prd_reg <= prd_nx;
      hi_us   <= hi_nx;
      u_reg   <= u_nx;
      t_reg   <= t_nx;
      cnt_reg <= cnt_nx;
      so_reg  <= so_nx;
      err_reg <= err_nx;
    end
  end

  assign bus.ready     = (state == IDLE);
  assign bus.done_tick = (state == DONE);
  assign bus.err       = (state == DONE) & err_reg;
  assign bus.so        = so_reg;
endmodule

// File: tb/tb_period_gen.sv
// Self-checking bench for period_gen: vector table, random bursts vs. a waveform model, corner sequences.
module tb_period_gen;
  localparam int M = 50;

  logic clk = 1'b0;
  logic reset;
  period_gen_if bus();

  period_gen #(.MAX_COUNTER_NUMBER(M)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int prd;
    int n;
    bit tog;
    bit exp_err;
    int exp_hi;
    int exp_lo;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Expected so at sample k after acceptance, from phase lengths in clocks.
  function automatic bit model_so(input int hi, input int lo, input int k);
    return (k % (hi + lo)) < hi;
  endfunction

  task automatic run_burst(input string nm, input int p, input int n, input bit tog,
                           input bit exp_err, input int hi, input int lo);
    int bad;
    @(negedge clk);
    bus.start = 1'b1;
    bus.prd   = 20'(p);
    bus.n_cyc = 8'(n);
    @(negedge clk);
    bus.start = 1'b0;
    if (exp_err) begin
      chk({nm, " reject done/err/so"}, {29'd0, bus.done_tick, bus.err, bus.so}, 32'b110);
    end else begin
      bad = 0;
      for (int k = 0; k < n * (hi + lo); k++) begin
        if (bus.so !== model_so(hi, lo, k) || bus.done_tick !== 1'b0 || bus.ready !== 1'b0) bad++;
        if (tog) begin
          bus.start = 1'($urandom);
          bus.prd   = 20'($urandom);
          bus.n_cyc = 8'($urandom);
        end
        @(negedge clk);
      end
      chk({nm, " waveform bad cycles"}, 32'(bad), 32'd0);
      bus.start = 1'b0;
      chk({nm, " done/err/so"}, {29'd0, bus.done_tick, bus.err, bus.so}, 32'b100);
    end
    @(negedge clk);
    chk({nm, " back to idle"}, {30'd0, bus.ready, bus.done_tick}, 32'b10);
  endtask

  vec_t vecs[7];

  initial begin
    int hi_cnt, lo_cnt, cyc;
    bit seen_done;
    vecs[0] = '{4, 1, 1'b0, 1'b0, 100, 100};
    vecs[1] = '{3, 3, 1'b0, 1'b0, 100, 50};
    vecs[2] = '{1, 5, 1'b0, 1'b1, 0, 0};
    vecs[3] = '{10, 0, 1'b0, 1'b1, 0, 0};
    vecs[4] = '{2, 2, 1'b1, 1'b0, 50, 50};
    vecs[5] = '{7, 2, 1'b0, 1'b0, 200, 150};
    vecs[6] = '{0, 3, 1'b0, 1'b1, 0, 0};

    bus.start = 1'b0;
    bus.prd   = '0;
    bus.n_cyc = '0;
    reset     = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("reset state ready/done/err/so",
        {28'd0, bus.ready, bus.done_tick, bus.err, bus.so}, 32'b1000);

    foreach (vecs[i])
      run_burst($sformatf("vec%0d", i), vecs[i].prd, vecs[i].n, vecs[i].tog,
                vecs[i].exp_err, vecs[i].exp_hi, vecs[i].exp_lo);

    for (int r = 0; r < 12; r++) begin
      int p, n;
      p = int'($urandom_range(0, 6));
      n = int'($urandom_range(0, 3));
      run_burst($sformatf("rnd%0d p=%0d n=%0d", r, p, n), p, n, 1'($urandom_range(0, 1)),
                (p < 2) || (n == 0), (p - p / 2) * M, (p / 2) * M);
    end

    // start held through DONE: must not be taken on the DONE->IDLE edge.
    @(negedge clk);
    bus.start = 1'b1;
    bus.prd   = 20'd0;
    bus.n_cyc = 8'd1;
    @(negedge clk);
    chk("held start: done pulse", {31'd0, bus.done_tick}, 32'd1);
    bus.prd = 20'd2;
    @(negedge clk);
    chk("held start: idle after done", {30'd0, bus.ready, bus.done_tick}, 32'b10);
    @(negedge clk);
    bus.start = 1'b0;
    chk("held start: accepted from idle", {30'd0, bus.ready, bus.so}, 32'b01);
    repeat (200) @(negedge clk);
    chk("held start: idle again", {31'd0, bus.ready}, 32'd1);

    // Reset mid-burst aborts without a done pulse.
    run_burst_abort: begin
      bus.start = 1'b1;
      bus.prd   = 20'd6;
      bus.n_cyc = 8'd2;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (120) @(negedge clk);
      chk("abort: high before reset", {31'd0, bus.so}, 32'd1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("abort: so/ready/done after reset",
          {29'd0, bus.so, bus.ready, bus.done_tick}, 32'b010);
      seen_done = 1'b0;
      repeat (400) begin
        @(negedge clk);
        if (bus.done_tick || bus.so) seen_done = 1'b1;
      end
      chk("abort: no later activity", {31'd0, seen_done}, 32'd0);
    end

    // Loopback period measurement at prd=1000.
    bus.start = 1'b1;
    bus.prd   = 20'd1000;
    bus.n_cyc = 8'd1;
    @(negedge clk);
    bus.start = 1'b0;
    hi_cnt = 0;
    lo_cnt = 0;
    cyc    = 0;
    while (!bus.done_tick && cyc < 60000) begin
      if (bus.so) hi_cnt++;
      else lo_cnt++;
      cyc++;
      @(negedge clk);
    end
    chk("loopback done within budget", {31'd0, bus.done_tick}, 32'd1);
    chk("loopback high clocks", 32'(hi_cnt), 32'd25000);
    chk("loopback period us", 32'((hi_cnt + lo_cnt) / M), 32'd1000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/period_gen.md
PERIOD_GEN -- requirements
Module: period_gen

Interface
REQ-001 SHALL have parameter MAX_COUNTER_NUMBER, default 50, clocks per microsecond (50 MHz clk).
REQ-002 SHALL have port clk  input  1  single system clock, all logic on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request to begin a burst; sampled only in IDLE.
REQ-005 SHALL have port prd  input  20  requested period in microseconds; sampled with start.
REQ-006 SHALL have port n_cyc  input  8  number of full periods to emit; sampled with start.
REQ-007 SHALL have port ready  output  1  high while in IDLE (combinational from state).
REQ-008 SHALL have port done_tick  output  1  one-clock pulse in DONE state.
REQ-009 SHALL have port err  output  1  high with done_tick when the request was rejected.
REQ-010 SHALL have port so  output  1  generated square wave, driven from a register.

Function
REQ-011 SHALL implement states IDLE, HIGH, LOW, DONE; any unused encoding SHALL go to IDLE.
REQ-012 In IDLE, with start=1, SHALL latch prd into prd_reg, n_cyc into cnt_reg, and compute hi_us = prd - floor(prd/2) and lo_us = floor(prd/2).
REQ-013 If the sampled prd < 2 or n_cyc = 0, SHALL go IDLE -> DONE, set err_reg=1, keep so=0.
REQ-014 Otherwise SHALL go IDLE -> HIGH, set so=1 on the same edge, clear the tick counter t_reg (7 bits) and the microsecond counter u_reg (20 bits), and set err_reg=0.
REQ-015 t_reg SHALL increment every clock in HIGH/LOW and wrap to 0 after MAX_COUNTER_NUMBER-1; each wrap SHALL increment u_reg.
REQ-016 On the edge where t_reg = MAX_COUNTER_NUMBER-1 and u_reg = hi_us-1 in HIGH, SHALL go to LOW, set so=0, and clear t_reg and u_reg.
REQ-017 On the edge where t_reg = MAX_COUNTER_NUMBER-1 and u_reg = lo_us-1 in LOW, SHALL decrement cnt_reg; if cnt_reg was 1, SHALL go to DONE with so=0; else SHALL go to HIGH, set so=1, and clear t_reg and u_reg.
REQ-018 Therefore so SHALL stay high for exactly hi_us*MAX_COUNTER_NUMBER clocks and low for exactly lo_us*MAX_COUNTER_NUMBER clocks per period, with no gap cycles between periods.
REQ-019 DONE SHALL last exactly one clock, with done_tick=1 and err=err_reg, then go to IDLE.
REQ-020 err SHALL be 0 whenever done_tick=0.
REQ-021 start SHALL be ignored outside IDLE; prd and n_cyc changes after acceptance SHALL NOT affect the burst in progress.
REQ-022 prd = 20'hFFFFF SHALL be supported without overflow (hi_us=524288, lo_us=524287).
REQ-023 Odd prd SHALL put the extra microsecond in the high phase.
REQ-024 start=1 in the same cycle as the DONE->IDLE transition SHALL NOT be accepted; acceptance SHALL occur only at an edge where the state is already IDLE.

Reset
REQ-025 With reset=1 at a clock edge, SHALL set state=IDLE, so=0, err_reg=0, and clear t_reg, u_reg, cnt_reg, prd_reg, hi_us and lo_us; this SHALL take priority over all other inputs.
REQ-026 Reset asserted mid-burst (HIGH or LOW) SHALL abort immediately, with so=0 on the next cycle and no done_tick.
REQ-027 After reset release, ready SHALL be 1 and done_tick SHALL be 0.

Verification
REQ-028 prd=4, n_cyc=1, start pulse -> so high 100 clocks, then low 100 clocks, then done_tick=1, err=0 for 1 clock, then ready=1.
REQ-029 prd=3, n_cyc=3 -> so sequence of 100 high / 50 low repeated 3 times with no gaps; single done_tick after the third low phase.
REQ-030 prd=1, n_cyc=5 and prd=10, n_cyc=0 -> done_tick=1 and err=1 one clock after acceptance; so stays 0.
REQ-031 prd=6, n_cyc=2; assert reset 120 clocks into the burst -> so=0 next cycle, state IDLE, no done_tick.
REQ-032 prd=2, n_cyc=2; toggle start, prd and n_cyc during the burst -> waveform unchanged (50 high / 50 low x2).
REQ-033 Loopback: drive so into the period counter with prd=1000 -> measured period = 1000.
